// File: rtl/udp_ip_cfg_sequencer.sv
// udp_ip_cfg_sequencer: AXI4-Lite master that writes a consecutive register bank from a flat
// configuration vector, optionally reads it back for comparison, and reports done/error status.
module udp_ip_cfg_sequencer #(
  parameter int                     NUM_REGS  = 4,
  parameter logic [31:0]            BASE_ADDR = 32'h0000_0000,
  parameter bit                     READBACK  = 1'b1,
  parameter logic [NUM_REGS*32-1:0] RB_MASK   = {NUM_REGS{32'hFFFF_FFFF}},
  parameter int                     TIMEOUT   = 1024
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     start,
  input  logic [NUM_REGS*32-1:0]   cfg_words,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [3:0]               err_index,
  output logic [2:0]               err_code,
  output logic [31:0]              m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [31:0]              m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH, FATAL} state_t;
  localparam int         CW   = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST = 4'(NUM_REGS - 1);

  state_t                 r_state;
  logic [3:0]             r_idx;
  logic [CW-1:0]          r_cnt;
  logic [NUM_REGS*32-1:0] r_shadow;
  logic [3:0]             w_nxt;
  logic [31:0]            w_nxt_addr, w_exp, w_mask;
  logic [2:0]             w_code;
  logic                   w_evt, w_to, w_end;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

  assign w_nxt      = r_idx + 4'd1;
  assign w_nxt_addr = BASE_ADDR + {26'd0, w_nxt, 2'b00};
  assign w_exp      = r_shadow[32*r_idx +: 32];
  assign w_mask     = RB_MASK[32*r_idx +: 32];

  // Completion event of the current state's handshake; anything else lets the timer run on.
  assign w_evt = (r_state == WR_REQ)  ? ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) :
                 (r_state == WR_RESP) ? m_axi_bvalid :
                 (r_state == RD_REQ)  ? m_axi_arready :
                 (r_state == RD_RESP) ? m_axi_rvalid : 1'b0;
  assign w_to  = (r_state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && !w_evt && (r_cnt == CW'(TIMEOUT - 1));

  assign w_code = (r_state == WR_RESP && m_axi_bresp != 2'b00) ? 3'd1 :
                  (r_state == RD_RESP && m_axi_rresp != 2'b00) ? 3'd2 :
                  (r_state == RD_RESP && ((m_axi_rdata ^ w_exp) & w_mask) != 32'd0) ? 3'd3 : 3'd0;
  assign w_end  = ((r_state == WR_RESP) && m_axi_bvalid && (w_code != 3'd0 || (r_idx == LAST && !READBACK))) ||
                  ((r_state == RD_RESP) && m_axi_rvalid && (w_code != 3'd0 || r_idx == LAST));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_shadow      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_index     <= '0;
      err_code      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      done  <= 1'b0;
      r_cnt <= r_cnt + CW'(1);
      if (w_to) begin
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} <= '0;
        busy      <= 1'b0;
        done      <= 1'b1;
        error     <= 1'b1;
        err_code  <= 3'd4;
        err_index <= r_idx;
        r_state   <= FATAL;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_shadow      <= cfg_words;
            error         <= 1'b0;
            err_index     <= '0;
            err_code      <= '0;
            busy          <= 1'b1;
            r_idx         <= '0;
            r_cnt         <= '0;
            m_axi_awaddr  <= BASE_ADDR;
            m_axi_wdata   <= cfg_words[31:0];
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            r_state       <= WR_REQ;
          end
          WR_REQ: begin
            if (m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wready) m_axi_wvalid <= 1'b0;
            if (w_evt) begin
              m_axi_bready <= 1'b1;
              r_state      <= WR_RESP;
            end
          end
          WR_RESP: if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (w_end) r_state <= FINISH;
            else if (r_idx == LAST) begin
              r_idx         <= '0;
              r_cnt         <= '0;
              m_axi_araddr  <= BASE_ADDR;
              m_axi_arvalid <= 1'b1;
              r_state       <= RD_REQ;
            end else begin
              r_idx         <= w_nxt;
              r_cnt         <= '0;
              m_axi_awaddr  <= w_nxt_addr;
              m_axi_wdata   <= r_shadow[32*w_nxt +: 32];
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              r_state       <= WR_REQ;
            end
          end
          RD_REQ: if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            r_state       <= RD_RESP;
          end
          RD_RESP: if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (w_end) r_state <= FINISH;
            else begin
              r_idx         <= w_nxt;
              r_cnt         <= '0;
              m_axi_araddr  <= w_nxt_addr;
              m_axi_arvalid <= 1'b1;
              r_state       <= RD_REQ;
            end
          end
          FINISH: r_state <= IDLE;
          default: ;
        endcase
        if (w_end) begin
          busy <= 1'b0;
          done <= 1'b1;
          if (w_code != 3'd0) begin
            error     <= 1'b1;
            err_code  <= w_code;
            err_index <= r_idx;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_udp_ip_cfg_sequencer.sv
// tb_udp_ip_cfg_sequencer: randomized AXI4-Lite slave with fault injection, compared against a
// transaction-level model of which writes/reads must appear and which error must be reported.
`timescale 1ns/1ps
module tb_udp_ip_cfg_sequencer;
  localparam int              N    = 4;
  localparam logic [31:0]     BASE = 32'hFFFF_FFF8;
  localparam logic [N*32-1:0] MASK = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
  localparam int              TMO  = 16;

  logic ACLK = 1'b0, ARESETN = 1'b0, start = 1'b0;
  logic [N*32-1:0] cfg_words = '0;
  logic busy, done, error;
  logic [3:0] err_index;
  logic [2:0] err_code, m_axi_awprot, m_axi_arprot;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [3:0] m_axi_wstrb;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_arready = 0, m_axi_rvalid = 0;
  logic [1:0] m_axi_bresp = 0, m_axi_rresp = 0;
  logic [31:0] m_axi_rdata = 0;

  udp_ip_cfg_sequencer #(.NUM_REGS(N), .BASE_ADDR(BASE), .READBACK(1'b1), .RB_MASK(MASK), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_words(cfg_words),
    .busy(busy), .done(done), .error(error), .err_index(err_index), .err_code(err_code),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0, failures = 0;
  int unsigned max_dly = 0;
  int fx_aw = 0, fx_w = 0, fx_b = 0, fx_ar = 0, fx_r = 0, b_err = -1, r_err = -1;
  bit never_aw = 0;
  logic [31:0] r_xor [N];
  logic [31:0] mem [N];
  int aw_d, w_d, b_d, ar_d, r_d, aw_c, w_c, b_c, ar_c, r_c;
  bit got_aw, got_w, got_ar;
  logic [31:0] cap_aw, cap_w, cap_ar;
  logic [31:0] wr_a[$], wr_d[$], rd_a[$], exp_wa[$], exp_wd[$], exp_ra[$];
  int exp_code, exp_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int fx);
    return (fx >= 0) ? fx : int'($urandom_range(max_dly));
  endfunction

  function automatic int ridx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'(d >> 2);
  endfunction

  // Expected bus traffic and outcome, derived straight from the register-programming rules.
  function automatic void model(input logic [N*32-1:0] cfg);
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    exp_code = 0; exp_idx = 0;
    for (int i = 0; i < N && exp_code == 0; i++) begin
      exp_wa.push_back(BASE + 32'(4 * i));
      exp_wd.push_back(cfg[32*i +: 32]);
      if (i == b_err) begin exp_code = 1; exp_idx = i; end
    end
    for (int i = 0; i < N && exp_code == 0; i++) begin
      exp_ra.push_back(BASE + 32'(4 * i));
      if (i == r_err) begin exp_code = 2; exp_idx = i; end
      else if ((r_xor[i] & MASK[32*i +: 32]) != 32'd0) begin exp_code = 3; exp_idx = i; end
    end
  endfunction

  initial begin
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    int ri;
    forever begin
      @(negedge ACLK);
      hs_aw = m_axi_awvalid && m_axi_awready;
      hs_w  = m_axi_wvalid && m_axi_wready;
      hs_b  = m_axi_bvalid && m_axi_bready;
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r  = m_axi_rvalid && m_axi_rready;
      if (hs_aw) cap_aw = m_axi_awaddr;
      if (hs_w) cap_w = m_axi_wdata;
      if (hs_ar) cap_ar = m_axi_araddr;
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      end else begin
        if (hs_aw) begin m_axi_awready = 0; got_aw = 1; aw_c = 0; aw_d = pick(fx_aw); end
        else if (m_axi_awvalid && !m_axi_awready && !never_aw) begin
          if (aw_c >= aw_d) m_axi_awready = 1; else aw_c++;
        end
        if (hs_w) begin m_axi_wready = 0; got_w = 1; w_c = 0; w_d = pick(fx_w); end
        else if (m_axi_wvalid && !m_axi_wready) begin
          if (w_c >= w_d) m_axi_wready = 1; else w_c++;
        end
        if (hs_b) begin m_axi_bvalid = 0; got_aw = 0; got_w = 0; b_c = 0; b_d = pick(fx_b); end
        else if (got_aw && got_w && !m_axi_bvalid) begin
          if (b_c >= b_d) begin
            ri = ridx(cap_aw);
            m_axi_bvalid = 1;
            m_axi_bresp = (ri == b_err) ? 2'b10 : 2'b00;
            wr_a.push_back(cap_aw);
            wr_d.push_back(cap_w);
            if (ri < N && ri != b_err) mem[ri] = cap_w;
          end else b_c++;
        end
        if (hs_ar) begin m_axi_arready = 0; got_ar = 1; ar_c = 0; ar_d = pick(fx_ar); end
        else if (m_axi_arvalid && !m_axi_arready) begin
          if (ar_c >= ar_d) m_axi_arready = 1; else ar_c++;
        end
        if (hs_r) begin m_axi_rvalid = 0; got_ar = 0; r_c = 0; r_d = pick(fx_r); end
        else if (got_ar && !m_axi_rvalid) begin
          if (r_c >= r_d) begin
            ri = ridx(cap_ar);
            m_axi_rvalid = 1;
            m_axi_rdata = (ri < N) ? mem[ri] ^ r_xor[ri] : 32'hDEAD_BEEF;
            m_axi_rresp = (ri == r_err) ? 2'b10 : 2'b00;
            rd_a.push_back(cap_ar);
          end else r_c++;
        end
      end
    end
  end

  task automatic arm_delays();
    aw_d = pick(fx_aw); w_d = pick(fx_w); b_d = pick(fx_b); ar_d = pick(fx_ar); r_d = pick(fx_r);
  endtask

  task automatic run_seq(input string tag, input logic [N*32-1:0] cfg, input int exp_busy, input int exp_awc, input int exp_wc);
    int n_busy, n_done, n_aw, n_w;
    bit fin;
    model(cfg);
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    arm_delays();
    n_busy = 0; n_done = 0; n_aw = 0; n_w = 0; fin = 0;
    @(negedge ACLK); start = 1; cfg_words = cfg;
    @(negedge ACLK); start = 0; cfg_words = ~cfg;
    for (int c = 0; c < 400 && !fin; c++) begin
      n_busy += int'(busy);
      n_aw += int'(m_axi_awvalid);
      n_w += int'(m_axi_wvalid);
      if (done) begin n_done++; fin = 1; end
      else begin start = (c == 3); @(negedge ACLK); end
    end
    start = 0;
    chk({tag, ":done_seen"}, 64'(fin), 1);
    repeat (2) begin @(negedge ACLK); n_done += int'(done); end
    chk({tag, ":done_once"}, 64'(n_done), 1);
    chk({tag, ":busy_after"}, 64'(busy), 0);
    chk({tag, ":error"}, 64'(error), 64'(exp_code != 0));
    chk({tag, ":err_code"}, 64'(err_code), 64'(exp_code));
    chk({tag, ":err_index"}, 64'(err_index), 64'(exp_idx));
    chk({tag, ":n_writes"}, 64'(wr_a.size()), 64'(exp_wa.size()));
    foreach (exp_wa[i]) if (i < wr_a.size()) begin
      chk({tag, ":wr_addr"}, 64'(wr_a[i]), 64'(exp_wa[i]));
      chk({tag, ":wr_data"}, 64'(wr_d[i]), 64'(exp_wd[i]));
    end
    chk({tag, ":n_reads"}, 64'(rd_a.size()), 64'(exp_ra.size()));
    foreach (exp_ra[i]) if (i < rd_a.size()) chk({tag, ":rd_addr"}, 64'(rd_a[i]), 64'(exp_ra[i]));
    if (exp_busy >= 0) chk({tag, ":busy_cycles"}, 64'(n_busy), 64'(exp_busy));
    if (exp_awc >= 0) begin
      chk({tag, ":aw_cycles"}, 64'(n_aw), 64'(exp_awc));
      chk({tag, ":w_cycles"}, 64'(n_w), 64'(exp_wc));
    end
  endtask

  task automatic directed(input int faw, input int be, input int re);
    max_dly = 0; fx_aw = faw; fx_w = 0; fx_b = 0; fx_ar = 0; fx_r = 0;
    b_err = be; r_err = re;
    foreach (r_xor[i]) r_xor[i] = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ":busy"}, 64'(busy), 0);
    chk({tag, ":done"}, 64'(done), 0);
    chk({tag, ":error"}, 64'(error), 0);
    chk({tag, ":err_code"}, 64'(err_code), 0);
    chk({tag, ":err_index"}, 64'(err_index), 0);
    chk({tag, ":valids"}, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 0);
    chk({tag, ":readies"}, 64'({m_axi_bready, m_axi_rready}), 0);
    chk({tag, ":addrs"}, 64'({m_axi_awaddr, m_axi_araddr}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*32-1:0] cfg;
    int n_aw, n_bad, k;
    bit fin;
    foreach (r_xor[i]) r_xor[i] = '0;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(negedge ACLK);
    chk_idle_outputs("reset_held");
    chk("wstrb", 64'(m_axi_wstrb), 64'hF);
    chk("prot", 64'({m_axi_awprot, m_axi_arprot}), 0);
    ARESETN = 1;
    @(negedge ACLK);
    chk_idle_outputs("reset_released");

    directed(0, -1, -1);
    run_seq("zero_wait", {32'd4, 32'd3, 32'd2, 32'd1}, 16, 4, 4);
    directed(5, -1, -1);
    run_seq("aw_stall", {32'hA4, 32'hA3, 32'hA2, 32'hA1}, -1, 24, 4);
    directed(0, 2, -1);
    run_seq("bresp_err", {32'd4, 32'd3, 32'd2, 32'd1}, -1, -1, -1);
    directed(0, -1, 3);
    run_seq("rresp_err", {32'd4, 32'd3, 32'd2, 32'd1}, -1, -1, -1);
    directed(0, -1, -1); r_xor[1] = 32'h10;
    run_seq("mismatch_r1", {32'd4, 32'd3, 32'd2, 32'd1}, -1, -1, -1);
    directed(0, -1, -1); r_xor[1] = 32'h1;
    run_seq("masked_r1", {32'd4, 32'd3, 32'd2, 32'd1}, 16, -1, -1);
    directed(0, -1, -1); r_xor[0] = 32'h1;
    run_seq("mismatch_r0", {32'd4, 32'd3, 32'd2, 32'd1}, -1, -1, -1);

    for (int t = 0; t < 24; t++) begin
      max_dly = 3; fx_aw = -1; fx_w = -1; fx_b = -1; fx_ar = -1; fx_r = -1;
      for (int i = 0; i < N; i++) cfg[32*i +: 32] = $urandom;
      b_err = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : -1;
      r_err = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : -1;
      foreach (r_xor[i]) r_xor[i] = '0;
      if ($urandom_range(2) == 0) r_xor[$urandom_range(N - 1)] = 32'd1 << $urandom_range(31);
      run_seq("random", cfg, -1, -1, -1);
    end

    // Write channel that never accepts: the timer must abandon the transaction and lock up.
    directed(0, -1, -1); never_aw = 1;
    arm_delays();
    @(negedge ACLK); start = 1; cfg_words = {32'd4, 32'd3, 32'd2, 32'd1};
    @(negedge ACLK); start = 0;
    n_aw = 0; fin = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      n_aw += int'(m_axi_awvalid);
      if (done) fin = 1; else @(negedge ACLK);
    end
    chk("tmo:done_seen", 64'(fin), 1);
    chk("tmo:aw_cycles", 64'(n_aw), TMO);
    chk("tmo:err_code", 64'(err_code), 4);
    chk("tmo:err_index", 64'(err_index), 0);
    chk("tmo:error", 64'(error), 1);
    @(negedge ACLK); start = 1;
    @(negedge ACLK); start = 0;
    n_bad = 0;
    repeat (20) begin
      n_bad += int'(busy) + int'(m_axi_awvalid) + int'(m_axi_wvalid) + int'(done);
      @(negedge ACLK);
    end
    chk("tmo:start_ignored", 64'(n_bad), 0);
    chk("tmo:err_sticky", 64'(err_code), 4);
    ARESETN = 0;
    #1;
    chk_idle_outputs("tmo_reset");
    @(negedge ACLK); ARESETN = 1; never_aw = 0;
    run_seq("after_fatal", {32'd8, 32'd7, 32'd6, 32'd5}, 16, -1, -1);

    // Asynchronous reset while a read response is outstanding.
    directed(0, -1, -1); fx_r = 10;
    arm_delays();
    @(negedge ACLK); start = 1; cfg_words = {32'd4, 32'd3, 32'd2, 32'd1};
    @(negedge ACLK); start = 0;
    k = 0;
    while (!m_axi_rready && k < 200) begin @(negedge ACLK); k++; end
    chk("rst_mid:reached_rd_resp", 64'(m_axi_rready), 1);
    #3 ARESETN = 0;
    #1;
    chk_idle_outputs("rst_mid");
    @(negedge ACLK); ARESETN = 1;
    directed(0, -1, -1);
    run_seq("after_reset", {32'h44, 32'h33, 32'h22, 32'h11}, 16, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
